// File: rtl/instr_fetch.sv
// RV32 instruction fetch: owns the PC, keeps one word read in flight to instruction
// memory, and hands each fetched instruction with its PC to decode under valid/ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_data_r;
    logic [31:0] instr_pc_r;
    logic [31:0] instr_pc_plus4_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;

    assign pc_plus4_s = pc_r + 32'd4;
    // The low two target bits are dropped so every fetch stays word aligned.
    assign target_s   = redirect_target & 32'hFFFF_FFFC;

    // Handshake strobes decode the state register only; no input reaches them.
    assign imem_req_valid = (state_r == S_REQ);
    assign instr_valid    = (state_r == S_HOLD);
    assign imem_req_addr  = pc_r;
    assign instr_data     = instr_data_r;
    assign instr_pc       = instr_pc_r;
    assign instr_pc_plus4 = instr_pc_plus4_r;

    // Fetch FSM: PC, state and the decode-facing instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= S_REQ;
            pc_r             <= RESET_PC;
            instr_data_r     <= 32'h0000_0000;
            instr_pc_r       <= 32'h0000_0000;
            instr_pc_plus4_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_r    <= target_s;
                        // An accepted old-address request must be drained first.
                        state_r <= imem_req_ready ? S_DRAIN : S_REQ;
                    end else if (imem_req_ready) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_r    <= target_s;
                        state_r <= imem_rsp_valid ? S_REQ : S_DRAIN;
                    end else if (imem_rsp_valid) begin
                        instr_data_r     <= imem_rsp_data;
                        instr_pc_r       <= pc_r;
                        instr_pc_plus4_r <= pc_plus4_s;
                        state_r          <= S_HOLD;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_r    <= target_s;
                        state_r <= S_REQ;
                    end else if (instr_ready) begin
                        pc_r    <= pc_plus4_s;
                        state_r <= S_REQ;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (redirect_valid) begin
                        pc_r    <= target_s;
                        state_r <= S_DRAIN;
                    end else if (imem_rsp_valid) begin
                        state_r <= S_REQ;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                default: begin
                    state_r <= S_REQ;
                    pc_r    <= RESET_PC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a bench-side memory model answers requests and a
// queue of expected PCs is checked at every decode handshake.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_ready;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          rsp_lat = 0;
    logic        pend   = 1'b0;
    logic [31:0] pend_addr = 32'h0000_0000;
    int          pend_cnt = 0;
    logic [31:0] exp_q[$];
    int          hs_cyc[$];

    instr_fetch #(.RESET_PC(32'h0000_1000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4),
        .instr_ready     (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard any decode handshake, advance, then update the memory model.
    task automatic cycle();
        logic        acc;
        logic        hs;
        logic        was_rst;
        logic [31:0] acc_addr;
        logic [31:0] e;
        acc      = (imem_req_valid === 1'b1) && imem_req_ready && !rst;
        acc_addr = imem_req_addr;
        hs       = (instr_valid === 1'b1) && instr_ready && !redirect_valid && !rst;
        was_rst  = rst;
        if (hs) begin
            hs_cyc.push_back(cyc);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL hs_unexpected observed_pc=%h expected=none", instr_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("hs_pc", instr_pc, e);
                check("hs_data", instr_data, mem_word(e));
                check("hs_pc_plus4", instr_pc_plus4, e + 32'd4);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        if (was_rst) pend = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = acc_addr;
            pend_cnt  = rsp_lat;
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        check("wait_instr_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_data;
        int          n;
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0000_0000;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0000_0000;
        instr_ready     = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rst_req_addr", imem_req_addr, 32'h0000_1000);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr_data", instr_data, 32'h0000_0000);
        check("rst_instr_pc", instr_pc, 32'h0000_0000);
        check("rst_instr_pc_plus4", instr_pc_plus4, 32'h0000_0000);

        // Streaming at minimum latency: one instruction every third cycle.
        exp_q.push_back(32'h0000_1000);
        exp_q.push_back(32'h0000_1004);
        exp_q.push_back(32'h0000_1008);
        for (int i = 0; i < 9; i++) cycle();
        check("stream_count", hs_cyc.size(), 32'd3);
        if (hs_cyc.size() == 3) begin
            check("stream_gap0", hs_cyc[1] - hs_cyc[0], 32'd3);
            check("stream_gap1", hs_cyc[2] - hs_cyc[1], 32'd3);
        end
        check("stream_next_addr", imem_req_addr, 32'h0000_100C);

        // Backpressure in HOLD.
        instr_ready = 1'b0;
        wait_valid(10);
        held_pc   = instr_pc;
        held_data = instr_data;
        check("bp_pc", held_pc, 32'h0000_100C);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_pc_stable", instr_pc, held_pc);
            check("bp_data_stable", instr_data, held_data);
            check("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        exp_q.push_back(32'h0000_100C);
        instr_ready = 1'b1;
        cycle();
        check("bp_release_req", {31'd0, imem_req_valid}, 32'd1);
        check("bp_release_addr", imem_req_addr, 32'h0000_1010);

        // Redirect while waiting; wrong-path response arrives three cycles later.
        rsp_lat = 3;
        cycle();
        check("wait_state_no_req", {31'd0, imem_req_valid}, 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_2002;
        cycle();
        rsp_lat = 0;
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 10) begin
            check("drain_no_instr", {31'd0, instr_valid}, 32'd0);
            cycle();
            n++;
        end
        check("drain_cycles", n, 32'd3);
        check("drain_target", imem_req_addr, 32'h0000_2000);
        exp_q.push_back(32'h0000_2000);
        wait_valid(10);
        cycle();

        // Redirect in the same cycle as a HOLD handshake.
        instr_ready = 1'b0;
        wait_valid(10);
        check("hold_pc", instr_pc, 32'h0000_2004);
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_3000;
        cycle();
        check("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);
        check("hold_redir_addr", imem_req_addr, 32'h0000_3000);
        check("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
        exp_q.push_back(32'h0000_3000);
        wait_valid(10);
        cycle();

        // Redirect in REQ without acceptance: immediate new request.
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_4000;
        cycle();
        check("req_noacc_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req_noacc_addr", imem_req_addr, 32'h0000_4000);

        // Redirect in REQ with acceptance: drain, then request the target.
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_4000;
        cycle();
        check("req_acc_drain", {31'd0, imem_req_valid}, 32'd0);
        cycle();
        check("req_acc_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req_acc_addr", imem_req_addr, 32'h0000_4000);
        check("req_acc_no_instr", {31'd0, instr_valid}, 32'd0);

        // PC wrap at the top of the address space.
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cycle();
        check("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        wait_valid(10);
        cycle();
        check("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        // Reset in WAIT.
        cycle();
        check("rstw_in_wait", {31'd0, imem_req_valid}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rstw_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rstw_req_addr", imem_req_addr, 32'h0000_1000);
        check("rstw_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rstw_instr_pc", instr_pc, 32'h0000_0000);
        exp_q.push_back(32'h0000_1000);
        wait_valid(10);
        cycle();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
